// File: rtl/uart_tx_arbiter_if.sv
// Bundles the source-side byte handshake and the transmitter port
// of the UART TX arbiter.
//   src_vld / src_data / src_rdy : N_REQ byte producers; source i's byte is on src_data[8i+7:8i]
//   tx_din / tx_req              : byte and request towards the UART transmitter
//   tx_req_ack / tx_finish       : transmitter latched the byte / finished the stop bit
//   tx_idle                      : transmitter idle flag
// master = producers plus transmitter, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   src_vld;
   logic [8*N_REQ-1:0] src_data;
   logic [N_REQ-1:0]   src_rdy;
   logic [7:0]         tx_din;
   logic               tx_req;
   logic               tx_req_ack;
   logic               tx_finish;
   logic               tx_idle;

   modport master (
      output src_vld, src_data, tx_req_ack, tx_finish, tx_idle,
      input  src_rdy, tx_din, tx_req
   );

   modport slave (
      input  src_vld, src_data, tx_req_ack, tx_finish, tx_idle,
      output src_rdy, tx_din, tx_req
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte sources.
// A granted byte is offered to the transmitter until it is acked, or until
// ACK_TIMEOUT request cycles pass, in which case the byte is dropped. The
// arbiter then waits for end of frame and inserts GAP_CLKS idle clocks.
//   CLK, rst_n  : system clock, asynchronous active-low reset
//   bus         : source handshake and transmitter port (slave side)
//   grant_id    : source index of the byte in flight
//   busy        : high whenever the FSM is not in IDLE
//   timeout_err : one-cycle pulse when a byte is dropped on ack timeout
//   sent_cnt    : completed frames, wraps modulo 2^CNT_W
//
// state | meaning
// IDLE  | waiting for tx_idle and a valid source; grants on the same edge
// REQ   | tx_req high, byte held; waiting for tx_req_ack or timeout
// BUSY  | byte accepted by the transmitter; waiting for tx_finish
// GAP   | inter-frame gap down-count before returning to IDLE
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ACK_TIMEOUT = 1024,
   parameter int GAP_CLKS    = 16,
   parameter int CNT_W       = 16
) (
   input  logic                     CLK,
   input  logic                     rst_n,
   uart_tx_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     timeout_err,
   output logic [CNT_W-1:0]         sent_cnt
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int T_MAX = (ACK_TIMEOUT > GAP_CLKS) ? ACK_TIMEOUT : GAP_CLKS;
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic [TMR_W-1:0] tmr;
   logic             found;
   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  pick_nxt;

   // first valid source at or after the round-robin pointer, wrapping
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && bus.src_vld[(int'(rr_ptr) + k) % N_REQ]) begin
            found = 1'b1;
            pick  = ID_W'((int'(rr_ptr) + k) % N_REQ);
         end
      end
      pick_nxt = (int'(pick) == N_REQ - 1) ? '0 : pick + ID_W'(1);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         tmr         <= '0;
         bus.src_rdy <= '0;
         bus.tx_din  <= '0;
         bus.tx_req  <= 1'b0;
         grant_id    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         sent_cnt    <= '0;
      end else begin
         bus.src_rdy <= '0;
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.tx_idle && found) begin
                  bus.tx_din  <= bus.src_data[8*int'(pick) +: 8];
                  grant_id    <= pick;
                  bus.src_rdy <= N_REQ'(1) << pick;
                  rr_ptr      <= pick_nxt;
                  bus.tx_req  <= 1'b1;
                  busy        <= 1'b1;
                  tmr         <= ACK_LOAD;
                  state       <= REQ;
               end
            end
            REQ: begin
               // an ack on the expiry cycle still counts as accepted
               if (bus.tx_req_ack) begin
                  bus.tx_req <= 1'b0;
                  state      <= BUSY;
               end else if (tmr == '0) begin
                  bus.tx_req  <= 1'b0;
                  timeout_err <= 1'b1;
                  if (GAP_CLKS == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     tmr   <= GAP_LOAD;
                     state <= GAP;
                  end
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            BUSY: begin
               if (bus.tx_finish) begin
                  sent_cnt <= sent_cnt + CNT_W'(1);
                  if (GAP_CLKS == 0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     tmr   <= GAP_LOAD;
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (tmr == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
